// File: rtl/audio_playback_sequencer.sv
// audio_playback_sequencer: read-side sequencer for the flash audio store.
// A trigger rise latches a clip selector, then the block steps raddr through
// the clip, capturing frdata[15:8] into a small prefetch FIFO after each
// address has settled. One sample is released to the AC97 path per ready rise.
//
// Ports:
//   clock, reset_b         - system clock, async active-low reset
//   enable                 - read mode allowed
//   clip_sel, trigger      - clip selector; trigger rise starts, fall aborts
//   ready                  - AC97 sample strobe (level, rising edge used)
//   writemode, doread      - flash_manager mode controls
//   raddr, frdata, busy    - flash_manager read port
//   to_ac97_data           - registered PCM sample
//   playing, done          - clip active / one-cycle natural end pulse
//   underrun_cnt           - saturating count of starved ready edges
module audio_playback_sequencer #(
    parameter int unsigned CLIP_BASE   = 1,
    parameter int unsigned CLIP_STRIDE = 12000,
    parameter int unsigned CLIP_LEN    = 12000,
    parameter int unsigned NUM_CLIPS   = 5,
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset_b,
    input  logic        enable,
    input  logic [3:0]  clip_sel,
    input  logic        trigger,
    input  logic        ready,
    output logic        writemode,
    output logic        doread,
    output logic [22:0] raddr,
    input  logic [15:0] frdata,
    input  logic        busy,
    output logic [7:0]  to_ac97_data,
    output logic        playing,
    output logic        done,
    output logic [7:0]  underrun_cnt
);

    localparam int unsigned AW    = 23;
    localparam int unsigned DW    = 8;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(SETTLE + 2);
    localparam logic [3:0]  LAST_SEL = 4'(NUM_CLIPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [AW-1:0]      raddr_d, end_addr, end_d;
    logic               writemode_d, doread_d, playing_d, done_d;
    logic [DW-1:0]      data_d;
    logic [7:0]         underrun_d;
    logic               ready_q, trig_q;

    logic [DW-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [OCC_W-1:0]   occ;

    logic               ready_rise_c, trig_rise_c, trig_fall_c;
    logic               push_c, pop_c, flush_c;
    logic [3:0]         sel_c;
    logic [AW-1:0]      start_c;
    logic               unused_c;

    // Low data byte is not part of the sample.
    assign unused_c = ^frdata[7:0];

    assign ready_rise_c = ready & ~ready_q;
    assign trig_rise_c  = trigger & ~trig_q;
    assign trig_fall_c  = ~trigger & trig_q;

    // Out-of-range selectors fold onto the last clip.
    assign sel_c   = (clip_sel >= LAST_SEL) ? LAST_SEL : clip_sel;
    assign start_c = AW'(CLIP_BASE) + AW'(sel_c) * AW'(CLIP_STRIDE);

    // Next-state, register updates and FIFO controls.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        raddr_d     = raddr;
        end_d       = end_addr;
        playing_d   = playing;
        done_d      = 1'b0;
        underrun_d  = underrun_cnt;
        data_d      = to_ac97_data;
        writemode_d = ~enable;
        doread_d    = enable;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        flush_c     = 1'b0;

        // Sample release; starved edges only count while a clip is active.
        if (ready_rise_c) begin
            if (playing && (occ != '0)) begin
                data_d = mem[rd_ptr];
                pop_c  = 1'b1;
            end else begin
                data_d = '0;
                if (playing && (underrun_cnt != 8'hFF)) begin
                    underrun_d = underrun_cnt + 8'd1;
                end
            end
        end

        if (!enable || (playing && trig_fall_c)) begin
            state_d   = S_IDLE;
            flush_c   = 1'b1;
            playing_d = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trig_rise_c) begin
                        raddr_d    = start_c;
                        end_d      = start_c + AW'(CLIP_LEN);
                        underrun_d = '0;
                        playing_d  = 1'b1;
                        cnt_d      = CNT_W'(SETTLE);
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - CNT_W'(1);
                    end else if (!busy) begin
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // A full FIFO parks here until the AC97 side pops.
                    if (occ != OCC_W'(FIFO_DEPTH)) begin
                        push_c  = 1'b1;
                        raddr_d = raddr + AW'(1);
                        cnt_d   = CNT_W'(SETTLE);
                        state_d = (raddr_d == end_addr) ? S_DRAIN : S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (occ == '0) begin
                        done_d    = 1'b1;
                        playing_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state        <= S_IDLE;
            cnt          <= '0;
            raddr        <= '0;
            end_addr     <= '0;
            writemode    <= 1'b1;
            doread       <= 1'b0;
            to_ac97_data <= '0;
            playing      <= 1'b0;
            done         <= 1'b0;
            underrun_cnt <= '0;
            ready_q      <= 1'b0;
            trig_q       <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            raddr        <= raddr_d;
            end_addr     <= end_d;
            writemode    <= writemode_d;
            doread       <= doread_d;
            to_ac97_data <= data_d;
            playing      <= playing_d;
            done         <= done_d;
            underrun_cnt <= underrun_d;
            ready_q      <= ready;
            trig_q       <= trigger;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occ unchanged.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush_c) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                occ <= occ + OCC_W'(1);
            end else if (pop_c && !push_c) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_ptr] <= frdata[15:8];
        end
    end

endmodule
